// File: rtl/mem_resp_model.sv
// Multi-channel valid/ready memory responder: per-channel FSM, shared storage, burst reads, backdoor access.
// Optional MEM_RESP_JITTER_EN adds a per-channel LFSR that stretches each request by 0..3 cycles.
module mem_resp_model #(
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 8,
    parameter int NUM_CHANNELS = 2,
    parameter int DEPTH        = 256,
    parameter int READ_NUM     = 1,
    parameter int LATENCY      = 5
) (
    input  logic                                             clk,
    input  logic                                             reset,
    input  logic [NUM_CHANNELS-1:0]                          mem_read_valid,
    input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]           mem_read_address,
    output logic [NUM_CHANNELS-1:0]                          mem_read_ready,
    output logic [NUM_CHANNELS-1:0][READ_NUM*DATA_BITS-1:0]  mem_read_data,
    input  logic [NUM_CHANNELS-1:0]                          mem_write_valid,
    input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]           mem_write_address,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]           mem_write_data,
    output logic [NUM_CHANNELS-1:0]                          mem_write_ready,
    input  logic                                             init_we,
    input  logic [ADDR_BITS-1:0]                             init_addr,
    input  logic [DATA_BITS-1:0]                             init_data,
    output logic [DATA_BITS-1:0]                             peek_data
);

    localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W   = $clog2(LATENCY + 4);
    localparam int BURST_W = READ_NUM * DATA_BITS;
    localparam logic [ADDR_BITS:0] DEPTH_X = (ADDR_BITS + 1)'(DEPTH);
    localparam logic [CNT_W-1:0]   LAT_M1  = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP, HOLD} state_t;
    typedef enum logic {OP_READ, OP_WRITE} op_t;

    // Storage is zeroed once at time zero and deliberately untouched by reset.
    logic [DATA_BITS-1:0] mem [DEPTH] = '{default: '0};

    logic [NUM_CHANNELS-1:0]                commit_en;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] commit_addr;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] commit_data;

    function automatic logic in_range(input logic [ADDR_BITS:0] a);
        return a < DEPTH_X;
    endfunction

    function automatic logic [DATA_BITS-1:0] read_word(input logic [ADDR_BITS:0] a);
        return in_range(a) ? mem[a[IDX_W-1:0]] : '0;
    endfunction

    // Burst indices are formed one bit wider than the address so they never wrap.
    function automatic logic [BURST_W-1:0] read_burst(input logic [ADDR_BITS-1:0] base);
        logic [BURST_W-1:0]   w;
        logic [ADDR_BITS:0]   a;
        w = '0;
        for (int i = 0; i < READ_NUM; i++) begin
            a = {1'b0, base} + (ADDR_BITS + 1)'(i);
            w[i*DATA_BITS +: DATA_BITS] = read_word(a);
        end
        return w;
    endfunction

    assign peek_data = read_word({1'b0, init_addr});

    // Backdoor first, then channels in ascending order: the last matching write on an edge wins.
    always_ff @(posedge clk) begin
        if (init_we && in_range({1'b0, init_addr}))
            mem[init_addr[IDX_W-1:0]] <= init_data;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (commit_en[c] && in_range({1'b0, commit_addr[c]}))
                mem[commit_addr[c][IDX_W-1:0]] <= commit_data[c];
        end
    end

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        state_t               state, state_nxt;
        op_t                  op;
        logic [CNT_W-1:0]     cnt, cnt_init;
        logic [ADDR_BITS-1:0] addr;
        logic [DATA_BITS-1:0] wdata;
        logic [BURST_W-1:0]   rdata;
        logic                 rd_ready, wr_ready;
        logic                 accept_rd, accept_wr, fire;

        always_comb begin
            state_nxt = state;
            accept_rd = 1'b0;
            accept_wr = 1'b0;
            fire      = 1'b0;
            case (state)
                IDLE: begin
                    if (mem_read_valid[c]) begin
                        accept_rd = 1'b1;
                        state_nxt = BUSY;
                    end else if (mem_write_valid[c]) begin
                        accept_wr = 1'b1;
                        state_nxt = BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        fire      = 1'b1;
                        state_nxt = RESP;
                    end
                end
                RESP:    state_nxt = HOLD;
                HOLD:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                state    <= IDLE;
                cnt      <= '0;
                rd_ready <= 1'b0;
                wr_ready <= 1'b0;
                rdata    <= '0;
            end else begin
                state    <= state_nxt;
                rd_ready <= fire && (op == OP_READ);
                wr_ready <= fire && (op == OP_WRITE);
                if (fire && (op == OP_READ))
                    rdata <= read_burst(addr);
                if (accept_rd || accept_wr)
                    cnt <= cnt_init;
                else if (state == BUSY && cnt != '0)
                    cnt <= cnt - CNT_W'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (accept_rd) begin
                addr <= mem_read_address[c];
                op   <= OP_READ;
            end else if (accept_wr) begin
                addr  <= mem_write_address[c];
                wdata <= mem_write_data[c];
                op    <= OP_WRITE;
            end
        end

`ifdef MEM_RESP_JITTER_EN
        logic [7:0] lfsr;

        assign cnt_init = LAT_M1 + CNT_W'(lfsr[1:0]);

        always_ff @(posedge clk) begin
            if (reset)
                lfsr <= 8'hA5 ^ 8'(c);
            else if (accept_rd || accept_wr)
                lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
`else
        assign cnt_init = LAT_M1;
`endif

        // A commit landing on a reset edge is discarded along with the request.
        assign commit_en[c]       = fire && (op == OP_WRITE) && !reset;
        assign commit_addr[c]     = addr;
        assign commit_data[c]     = wdata;
        assign mem_read_ready[c]  = rd_ready;
        assign mem_write_ready[c] = wr_ready;
        assign mem_read_data[c]   = rdata;
    end

endmodule

// File: tb/tb_mem_resp_model.sv
// Testbench for mem_resp_model: directed plan plus randomized two-channel traffic against an array model.
module tb_mem_resp_model;

    localparam int LAT = 5;
    localparam int WIN = LAT + 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]       a_rv, a_rr, a_wv, a_wr;
    logic [1:0][7:0]  a_ra, a_rd, a_wa, a_wd;
    logic             a_iwe;
    logic [7:0]       a_iaddr, a_idata, a_peek;

    logic [1:0]       b_rv, b_rr, b_wv, b_wr;
    logic [1:0][7:0]  b_ra, b_wa, b_wd;
    logic [1:0][31:0] b_rd;
    logic             b_iwe;
    logic [7:0]       b_iaddr, b_idata, b_peek;

    mem_resp_model #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CHANNELS(2), .DEPTH(64),
                     .READ_NUM(1), .LATENCY(LAT)) u_a (
        .clk(clk), .reset(reset),
        .mem_read_valid(a_rv), .mem_read_address(a_ra), .mem_read_ready(a_rr), .mem_read_data(a_rd),
        .mem_write_valid(a_wv), .mem_write_address(a_wa), .mem_write_data(a_wd), .mem_write_ready(a_wr),
        .init_we(a_iwe), .init_addr(a_iaddr), .init_data(a_idata), .peek_data(a_peek)
    );

    mem_resp_model #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CHANNELS(2), .DEPTH(29),
                     .READ_NUM(4), .LATENCY(LAT)) u_b (
        .clk(clk), .reset(reset),
        .mem_read_valid(b_rv), .mem_read_address(b_ra), .mem_read_ready(b_rr), .mem_read_data(b_rd),
        .mem_write_valid(b_wv), .mem_write_address(b_wa), .mem_write_data(b_wd), .mem_write_ready(b_wr),
        .init_we(b_iwe), .init_addr(b_iaddr), .init_data(b_idata), .peek_data(b_peek)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] ref_a [64];
    int lat_log [16];
    int lat_n = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_rd(input logic [7:0] ad);
        return (ad < 8'd64) ? ref_a[ad[5:0]] : 8'h00;
    endfunction

    task automatic peek_a(input string tag, input logic [7:0] ad);
        a_iaddr = ad;
        #1;
        check(tag, 64'(a_peek), 64'(model_rd(ad)));
    endtask

    task automatic load_a(input logic [7:0] ad, input logic [7:0] d);
        @(negedge clk);
        a_iwe = 1'b1; a_iaddr = ad; a_idata = d;
        @(negedge clk);
        a_iwe = 1'b0;
        if (ad < 8'd64) ref_a[ad[5:0]] = d;
    endtask

    task automatic load_b(input logic [7:0] ad, input logic [7:0] d);
        @(negedge clk);
        b_iwe = 1'b1; b_iaddr = ad; b_idata = d;
        @(negedge clk);
        b_iwe = 1'b0;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1;
        repeat (n) @(negedge clk);
        check("rst_a_rready", 64'(a_rr), 64'd0);
        check("rst_a_wready", 64'(a_wr), 64'd0);
        check("rst_a_rdata", 64'(a_rd), 64'd0);
        check("rst_b_rdata", 64'(b_rd), 64'd0);
        reset = 1'b0;
    endtask

    // One transaction on instance A: both channels launched on the same edge, optional
    // reset pulse (rst_at = negedge index, 0 = none) and optional backdoor write on the commit edge.
    task automatic run_a(input logic [1:0] rd, input logic [1:0] wr,
                         input logic [7:0] ad0, input logic [7:0] ad1,
                         input logic [7:0] wd0, input logic [7:0] wd1,
                         input int rst_at, input logic bd,
                         input logic [7:0] bd_ad, input logic [7:0] bd_d);
        logic [7:0] ad [2];
        logic [7:0] wd [2];
        logic [7:0] exp_rd [2];
        logic [7:0] got [2];
        int rcnt [2];
        int wcnt [2];
        int rlat [2];
        int wlat [2];
        logic exp_r, exp_w;
        ad[0] = ad0; ad[1] = ad1; wd[0] = wd0; wd[1] = wd1;
        for (int c = 0; c < 2; c++) begin
            exp_rd[c] = model_rd(ad[c]);
            got[c] = '0; rcnt[c] = 0; wcnt[c] = 0; rlat[c] = 0; wlat[c] = 0;
        end
        @(negedge clk);
        a_rv = rd; a_wv = wr;
        a_ra[0] = ad0; a_ra[1] = ad1; a_wa[0] = ad0; a_wa[1] = ad1;
        a_wd[0] = wd0; a_wd[1] = wd1;
        for (int k = 1; k <= WIN; k++) begin
            @(negedge clk);
            for (int c = 0; c < 2; c++) begin
                if (a_rr[c]) begin rcnt[c]++; rlat[c] = k; got[c] = a_rd[c]; end
                if (a_wr[c]) begin wcnt[c]++; wlat[c] = k; end
            end
            if (rst_at != 0 && k == rst_at + 1)
                check("rst_mid_rdata", 64'(a_rd), 64'd0);
            if (k == 1) begin a_rv = '0; a_wv = '0; end
            reset = 1'b0;
            a_iwe = 1'b0;
            if (rst_at == k) reset = 1'b1;
            if (bd && k == LAT) begin a_iwe = 1'b1; a_iaddr = bd_ad; a_idata = bd_d; end
        end
        for (int c = 0; c < 2; c++) begin
            exp_r = (rst_at == 0) && rd[c];
            exp_w = (rst_at == 0) && !rd[c] && wr[c];
            check("rd_ready_cnt", 64'(rcnt[c]), 64'(exp_r));
            check("wr_ready_cnt", 64'(wcnt[c]), 64'(exp_w));
            if (exp_r) begin
                check("rd_data", 64'(got[c]), 64'(exp_rd[c]));
                check("rd_hold", 64'(a_rd[c]), 64'(exp_rd[c]));
`ifdef MEM_RESP_JITTER_EN
                check("rd_lat_range", 64'(rlat[c] >= LAT + 1 && rlat[c] <= LAT + 4), 64'd1);
`else
                check("rd_lat", 64'(rlat[c]), 64'(LAT + 1));
`endif
                if (c == 0 && lat_n < 16) begin lat_log[lat_n] = rlat[0]; lat_n++; end
            end
            if (exp_w) begin
`ifdef MEM_RESP_JITTER_EN
                check("wr_lat_range", 64'(wlat[c] >= LAT + 1 && wlat[c] <= LAT + 4), 64'd1);
`else
                check("wr_lat", 64'(wlat[c]), 64'(LAT + 1));
`endif
            end
        end
        if (bd && bd_ad < 8'd64) ref_a[bd_ad[5:0]] = bd_d;
        if (rst_at == 0) begin
            for (int c = 0; c < 2; c++)
                if (!rd[c] && wr[c] && ad[c] < 8'd64) ref_a[ad[c][5:0]] = wd[c];
        end
        for (int c = 0; c < 2; c++)
            if (wr[c]) peek_a("peek_wr", ad[c]);
        if (bd) peek_a("peek_bd", bd_ad);
    endtask

    task automatic run_b(input logic [7:0] ad, input logic [31:0] exp);
        int cnt;
        logic [31:0] got;
        cnt = 0; got = '0;
        @(negedge clk);
        b_rv = 2'b01; b_ra[0] = ad;
        for (int k = 1; k <= WIN; k++) begin
            @(negedge clk);
            if (k == 1) b_rv = '0;
            if (b_rr[0]) begin cnt++; got = b_rd[0]; end
        end
        check("b_ready_cnt", 64'(cnt), 64'd1);
        check("b_burst", 64'(got), 64'(exp));
        check("b_hold", 64'(b_rd[0]), 64'(exp));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed no completion, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] r, w;
        logic [7:0] x0, x1, d0, d1;
        a_rv = '0; a_wv = '0; a_ra = '0; a_wa = '0; a_wd = '0;
        a_iwe = 1'b0; a_iaddr = '0; a_idata = '0;
        b_rv = '0; b_wv = '0; b_ra = '0; b_wa = '0; b_wd = '0;
        b_iwe = 1'b0; b_iaddr = '0; b_idata = '0;
        for (int i = 0; i < 64; i++) ref_a[i] = 8'h00;

        do_reset(3);
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 4; j++)
                load_a(8'(i * 4 + j), 8'(i + j));

`ifdef MEM_RESP_JITTER_EN
        for (int n = 0; n < 8; n++)
            run_a(2'b01, 2'b00, 8'(n * 2), 8'd0, 8'd0, 8'd0, 0, 1'b0, 8'd0, 8'd0);
        do_reset(2);
        for (int n = 0; n < 8; n++)
            run_a(2'b01, 2'b00, 8'(n * 2), 8'd0, 8'd0, 8'd0, 0, 1'b0, 8'd0, 8'd0);
        check("jitter_log_len", 64'(lat_n), 64'd16);
        for (int n = 0; n < 8; n++)
            check("jitter_repeat", 64'(lat_log[n + 8]), 64'(lat_log[n]));
`else
        // Single read, then both channels reading together.
        run_a(2'b01, 2'b00, 8'd9, 8'd0, 8'd0, 8'd0, 0, 1'b0, 8'd0, 8'd0);
        run_a(2'b11, 2'b00, 8'd5, 8'd17, 8'd0, 8'd0, 0, 1'b0, 8'd0, 8'd0);

        // Write collision, then read racing a write, then read-back.
        run_a(2'b00, 2'b11, 8'd20, 8'd20, 8'd26, 8'd40, 0, 1'b0, 8'd0, 8'd0);
        run_a(2'b01, 2'b10, 8'd20, 8'd20, 8'd0, 8'd7, 0, 1'b0, 8'd0, 8'd0);
        run_a(2'b01, 2'b00, 8'd20, 8'd0, 8'd0, 8'd0, 0, 1'b0, 8'd0, 8'd0);

        // Burst reads on the DEPTH=29, READ_NUM=4 instance.
        for (int i = 0; i < 5; i++) load_b(8'(24 + i), 8'(i + 1));
        run_b(8'd24, 32'h04030201);
        run_b(8'd27, 32'h00000504);
        run_b(8'd22, 32'h02010000);

        // Reset during BUSY and exactly on the commit edge.
        run_a(2'b00, 2'b01, 8'd3, 8'd0, 8'd99, 8'd0, 2, 1'b0, 8'd0, 8'd0);
        run_a(2'b00, 2'b01, 8'd3, 8'd0, 8'd99, 8'd0, LAT, 1'b0, 8'd0, 8'd0);
        run_a(2'b01, 2'b00, 8'd3, 8'd0, 8'd0, 8'd0, 0, 1'b0, 8'd0, 8'd0);

        // Out-of-range write, and channel write against a same-edge backdoor write.
        run_a(2'b00, 2'b01, 8'd200, 8'd0, 8'd55, 8'd0, 0, 1'b0, 8'd0, 8'd0);
        peek_a("peek_alias", 8'd8);
        run_a(2'b00, 2'b10, 8'd0, 8'd30, 8'd0, 8'd11, 0, 1'b1, 8'd30, 8'd22);

        // Randomized two-channel traffic, biased toward a small shared address window.
        for (int it = 0; it < 24; it++) begin
            r  = 2'($urandom_range(0, 3));
            w  = 2'($urandom_range(0, 3));
            x0 = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(16, 23)) : 8'($urandom_range(0, 71));
            x1 = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(16, 23)) : 8'($urandom_range(0, 71));
            d0 = 8'($urandom_range(0, 255));
            d1 = 8'($urandom_range(0, 255));
            run_a(r, w, x0, x1, d0, d1, 0, 1'b0, 8'd0, 8'd0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_resp_model.md
Name: mem_resp_model

Overview:
- Parametrised, clocked multi-channel memory responder for GPU simulation benches. It replaces the ad hoc fixed-latency program/data memory processes.
- Serves NUM_CHANNELS independent valid/ready channels against one shared storage array. Latency is configurable, and each read can return a multi-word burst.
- One instance models program memory (READ_NUM>1, writes tied off); another models data memory (READ_NUM=1).
- Sits directly on the gpu top-level memory ports. A backdoor port preloads and inspects contents.

Parameters:
- ADDR_BITS, 8, address width.
- DATA_BITS, 8, word width.
- NUM_CHANNELS, 2, independent request channels.
- DEPTH, 256, words implemented (must be <= 2**ADDR_BITS).
- READ_NUM, 1, words returned per read (burst), packed word i at [i*DATA_BITS +: DATA_BITS].
- LATENCY, 5, cycles from request acceptance to ready pulse (>=1).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- mem_read_valid  input  NUM_CHANNELS  per-channel read request.
- mem_read_address  input  [NUM_CHANNELS] x ADDR_BITS  read address.
- mem_read_ready  output  NUM_CHANNELS  one-cycle read completion pulse.
- mem_read_data  output  [NUM_CHANNELS] x READ_NUM*DATA_BITS  read burst data.
- mem_write_valid  input  NUM_CHANNELS  per-channel write request.
- mem_write_address  input  [NUM_CHANNELS] x ADDR_BITS  write address.
- mem_write_data  input  [NUM_CHANNELS] x DATA_BITS  write data.
- mem_write_ready  output  NUM_CHANNELS  one-cycle write completion pulse.
- init_we  input  1  backdoor write strobe.
- init_addr  input  ADDR_BITS  backdoor address (shared by write and peek).
- init_data  input  DATA_BITS  backdoor write data.
- peek_data  output  DATA_BITS  combinational mem[init_addr]; 0 if out of range.

Behaviour:
- Clock and reset: single clock clk; reset synchronous, active-high.
- Reset values:
  - all ready outputs 0; all read_data 0; per-channel FSMs to IDLE; latency counters 0.
  - Storage is NOT cleared by reset; it is initialised to 0 only at time zero.
- Per-channel FSM states: IDLE, BUSY, RESP, HOLD.
- IDLE:
  - If read_valid is high, latch the address, set op=READ and counter=LATENCY-1, go to BUSY.
  - Else if write_valid is high, latch address and data, set op=WRITE, go to BUSY.
  - Read has priority when both are high; the write is served on a later request.
- BUSY:
  - Decrement the counter each cycle.
  - At counter==0, on that edge: a READ captures the burst; a WRITE commits to storage. Go to RESP.
  - With LATENCY=1, BUSY lasts one cycle.
- RESP:
  - The matching ready is high for exactly this cycle; read_data is held stable from this cycle until the next capture.
  - Go to HOLD.
- HOLD:
  - One cycle in which the channel's valids are ignored (the requester drops valid the cycle after ready).
  - Go to IDLE.
- Latency: acceptance edge to ready high = LATENCY+1 clock edges. Channel throughput is one request per LATENCY+3 cycles.
- Address rules:
  - Burst word i comes from latched_addr+i, computed in ADDR_BITS+1 bits with no wrap.
  - An index >= DEPTH returns 0 for that word.
  - A write to an address >= DEPTH is dropped silently, but ready still pulses.
- Simultaneous events:
  - Same-edge write commit and read capture at the same address (any channels): the read returns the pre-write value.
  - Two channels commit writes to the same address on one edge: the higher channel index wins.
  - Channel writes take priority over init_we at the same address.
- Valid deasserted while in BUSY: the request still completes (no abort).
- Reset mid-operation:
  - In-flight requests are discarded and no ready is issued.
  - A write whose commit edge coincides with reset is NOT committed.
- Channels are fully independent: no arbitration and no shared counters.

Optional Feature:
- Macro: MEM_RESP_JITTER_EN.
- When defined:
  - Each channel has an 8-bit LFSR (x^8+x^6+x^5+x^4+1), reset to seed 8'hA5 ^ channel index.
  - At acceptance, counter = LATENCY-1 + (lfsr[1:0]), and the LFSR advances one step per accepted request.
  - Total per-request latency ranges over LATENCY..LATENCY+3 and is deterministic from reset.
- When undefined: latency is exactly LATENCY; there is no LFSR logic.

Test Plan:
- Setup: DEPTH=64, READ_NUM=1, LATENCY=5. Preload mem[i*4+j]=i+j for i<5, j<4 via init_we.
  - Read ch0 at address 9 -> ready0 pulses 6 edges after acceptance, data=3; ready1 stays 0.
- Same setup, both channels together: read ch0 at address 5 and ch1 at address 17 in the same cycle -> both readies pulse in the same cycle, data 2 and 5.
- Write collision: ch0 writes 20<-26 while ch1 writes 20<-40 in the same cycle -> peek at 20 returns 40; both write_readies pulse.
- Read during write:
  - Ch0 reads 20 while ch1 writes 20<-7 with aligned commit/capture -> read returns the old value.
  - A subsequent read of 20 returns 7.
- Burst reads with READ_NUM=4, DEPTH=29:
  - Read at 24 with mem[24..28]=1..5 -> data words {4,3,2,1} (word0 = 1).
  - Read at 27 -> words {0,0,5,4}.
- Reset and limits:
  - Assert reset for one cycle in BUSY of a write 3<-99 -> no ready, mem[3] unchanged; the next request completes normally.
  - Write to address 200 with DEPTH=64 -> ready pulses, storage unchanged.
- Jitter (MEM_RESP_JITTER_EN defined, LATENCY=5): 8 back-to-back ch0 reads -> every latency is within 5..8, and the sequence repeats identically after reset.
